// File: rtl/assoc_argmax_26p.sv
// ---------------------------------------------------------------------------
// assoc_argmax_26p
// Classification stage behind the associative-memory accumulator bank.
// On start it snapshots every class score. It then scans the snapshot with
// one comparison per cycle and presents the winning class index, its score
// and a tie flag under a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   nrst       in   asynchronous reset, active HIGH (1 clears the block)
//   start      in   snapshot scores_in and begin a search (IDLE only)
//   scores_in  in   packed scores, class k at [k*SCORE_W +: SCORE_W]
//   busy       out  high while scanning or holding a result
//   res_valid  out  result available
//   res_ready  in   consumer accepts the result when res_valid && res_ready
//   class_idx  out  index of the winning class (lowest index on ties)
//   max_score  out  winning score
//   tie        out  another class has the same score as the winner
// ---------------------------------------------------------------------------
module assoc_argmax_26p #(
   parameter int NUM_CLASSES = 26,
   parameter int SCORE_W     = 7,
   parameter int IDX_W       = 5
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic                           start,
   input  logic [NUM_CLASSES*SCORE_W-1:0] scores_in,
   output logic                           busy,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [IDX_W-1:0]               class_idx,
   output logic [SCORE_W-1:0]             max_score,
   output logic                           tie
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   logic [1:0]                     state_q,      state_d;
   logic [NUM_CLASSES*SCORE_W-1:0] snap_q,       snap_d;
   logic [IDX_W-1:0]               cnt_q,        cnt_d;
   logic [SCORE_W-1:0]             best_score_q, best_score_d;
   logic [IDX_W-1:0]               best_idx_q,   best_idx_d;
   logic                           tie_r_q,      tie_r_d;
   logic                           last_q,       last_d;
   logic                           res_valid_q,  res_valid_d;
   logic [IDX_W-1:0]               class_idx_q,  class_idx_d;
   logic [SCORE_W-1:0]             max_score_q,  max_score_d;
   logic                           tie_q,        tie_d;

   logic [SCORE_W-1:0]             cur_score_s;

   // Snapshot entry under comparison this cycle.
   assign cur_score_s = snap_q[int'(cnt_q)*SCORE_W +: SCORE_W];

   // Next-state logic for the snapshot / scan / handshake sequence.
   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      cnt_d        = cnt_q;
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
      tie_r_d      = tie_r_q;
      last_d       = last_q;
      res_valid_d  = res_valid_q;
      class_idx_d  = class_idx_q;
      max_score_d  = max_score_q;
      tie_d        = tie_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               snap_d       = scores_in;
               best_score_d = scores_in[SCORE_W-1:0];
               best_idx_d   = '0;
               tie_r_d      = 1'b0;
               cnt_d        = IDX_W'(1);
               last_d       = 1'b0;
               state_d      = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SCAN: begin
            if (last_q) begin
               // The final comparison has settled in best_*; publish it one
               // edge later so res_valid lands NUM_CLASSES edges after start.
               class_idx_d = best_idx_q;
               max_score_d = best_score_q;
               tie_d       = tie_r_q;
               res_valid_d = 1'b1;
               last_d      = 1'b0;
               state_d     = ST_DONE;
            end else begin
               if (cur_score_s > best_score_q) begin
                  best_score_d = cur_score_s;
                  best_idx_d   = cnt_q;
                  tie_r_d      = 1'b0;
               end else if (cur_score_s == best_score_q) begin
                  // Keep the earlier index: ties go to the lowest class.
                  tie_r_d = 1'b1;
               end else begin
                  tie_r_d = tie_r_q;
               end
               // Counter parks on the last class instead of wrapping.
               if (cnt_q == LAST_IDX) begin
                  last_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end

         ST_DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state_q      <= ST_IDLE;
         snap_q       <= '0;
         cnt_q        <= '0;
         best_score_q <= '0;
         best_idx_q   <= '0;
         tie_r_q      <= 1'b0;
         last_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         class_idx_q  <= '0;
         max_score_q  <= '0;
         tie_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         cnt_q        <= cnt_d;
         best_score_q <= best_score_d;
         best_idx_q   <= best_idx_d;
         tie_r_q      <= tie_r_d;
         last_q       <= last_d;
         res_valid_q  <= res_valid_d;
         class_idx_q  <= class_idx_d;
         max_score_q  <= max_score_d;
         tie_q        <= tie_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign res_valid = res_valid_q;
   assign class_idx = class_idx_q;
   assign max_score = max_score_q;
   assign tie       = tie_q;

endmodule

// File: tb/tb_assoc_argmax_26p.sv
// ---------------------------------------------------------------------------
// tb_assoc_argmax_26p
// Self-checking bench for assoc_argmax_26p. A transaction-level model
// (argmax of the captured score vector, published N edges after start) is
// compared against the DUT on every falling edge. Directed scenarios add
// literal expectations.
// ---------------------------------------------------------------------------
module tb_assoc_argmax_26p;

   localparam int N  = 26;
   localparam int W  = 7;
   localparam int IW = 5;

   logic           clk = 1'b0;
   logic           nrst;
   logic           start;
   logic [N*W-1:0] scores_in;
   logic           busy;
   logic           res_valid;
   logic           res_ready;
   logic [IW-1:0]  class_idx;
   logic [W-1:0]   max_score;
   logic           tie;

   int n_tests = 0;
   int n_fail  = 0;

   assoc_argmax_26p dut (
      .clk       (clk),
      .nrst      (nrst),
      .start     (start),
      .scores_in (scores_in),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .class_idx (class_idx),
      .max_score (max_score),
      .tie       (tie)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: {tie, max score, lowest index holding the max}.
   function automatic logic [IW+W:0] argmax_vec(input logic [N*W-1:0] v);
      int best;
      int bi;
      int cnt;
      best = -1;
      bi   = 0;
      for (int k = 0; k < N; k++) begin
         if (int'(v[k*W +: W]) > best) begin
            best = int'(v[k*W +: W]);
            bi   = k;
         end
      end
      cnt = 0;
      for (int k = 0; k < N; k++) begin
         if (int'(v[k*W +: W]) == best) cnt++;
      end
      return {(cnt > 1), W'(best), IW'(bi)};
   endfunction

   // ---------------- transaction-level model ----------------
   logic           m_busy;
   logic           m_valid;
   int             m_cd;
   logic [IW+W:0]  m_pend;
   logic [IW+W:0]  m_res;

   // Model state advance on each clock edge.
   always @(posedge clk or posedge nrst) begin
      if (nrst) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_cd    <= 0;
         m_pend  <= '0;
         m_res   <= '0;
      end else if (!m_busy) begin
         if (start) begin
            m_pend <= argmax_vec(scores_in);
            m_cd   <= N;
            m_busy <= 1'b1;
         end
      end else if (m_cd > 0) begin
         m_cd <= m_cd - 1;
         if (m_cd == 1) begin
            m_res   <= m_pend;
            m_valid <= 1'b1;
         end
      end else if (res_ready) begin
         m_valid <= 1'b0;
         m_busy  <= 1'b0;
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   int   results_seen = 0;
   logic prev_valid   = 1'b0;
   always @(negedge clk) begin
      if (!nrst) begin
         chk("busy",      int'(busy),      int'(m_busy));
         chk("res_valid", int'(res_valid), int'(m_valid));
         chk("class_idx", int'(class_idx), int'(m_res[IW-1:0]));
         chk("max_score", int'(max_score), int'(m_res[IW+W-1:IW]));
         chk("tie",       int'(tie),       int'(m_res[IW+W]));
         if (res_valid && !prev_valid) results_seen <= results_seen + 1;
         prev_valid <= res_valid;
      end else begin
         prev_valid <= 1'b0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_s(input int k, input int v);
      scores_in[k*W +: W] = W'(v);
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_busy"},  int'(busy),      0);
      chk({nm, "_valid"}, int'(res_valid), 0);
      chk({nm, "_idx"},   int'(class_idx), 0);
      chk({nm, "_score"}, int'(max_score), 0);
      chk({nm, "_tie"},   int'(tie),       0);
   endtask

   // Pulse start, measure latency, check result literals, hold, handshake.
   task automatic run_check(input string nm, input int e_idx, input int e_sc,
                            input int e_tie, input int hold);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!res_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_latency"}, cyc, N);
      chk({nm, "_idx"},   int'(class_idx), e_idx);
      chk({nm, "_score"}, int'(max_score), e_sc);
      chk({nm, "_tie"},   int'(tie),       e_tie);
      repeat (hold) @(negedge clk);
      chk({nm, "_held_valid"}, int'(res_valid), 1);
      chk({nm, "_held_idx"},   int'(class_idx), e_idx);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({nm, "_ack_valid"}, int'(res_valid), 0);
      chk({nm, "_ack_busy"},  int'(busy),      0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [N*W-1:0] tv;
      logic [IW+W:0]  r;
      logic [IW+W:0]  exp_snap;
      int             seen0;
      int             lim;

      nrst      = 1'b1;
      start     = 1'b0;
      res_ready = 1'b0;
      scores_in = '0;

      // Pin the reference function with hand-computed cases.
      tv = '0;
      tv[17*W +: W] = 7'd90;
      r = argmax_vec(tv);
      chk("pin_idx17", int'(r[IW-1:0]), 17);
      chk("pin_sc90",  int'(r[IW+W-1:IW]), 90);
      chk("pin_tie0",  int'(r[IW+W]), 0);
      tv = '0;
      r = argmax_vec(tv);
      chk("pin_zero_idx", int'(r[IW-1:0]), 0);
      chk("pin_zero_tie", int'(r[IW+W]), 1);

      #3;
      check_all_zero("rst_init");
      repeat (2) @(negedge clk);
      nrst = 1'b0;

      // Single maximum, held 5 cycles.
      for (int k = 0; k < N; k++) set_s(k, 10);
      set_s(17, 90);
      run_check("single", 17, 90, 0, 5);

      // Tie resolves to lowest index.
      scores_in = '0;
      set_s(3, 127);
      set_s(25, 127);
      run_check("tie_lo", 3, 127, 1, 1);
      scores_in = '0;
      set_s(25, 127);
      set_s(24, 127);
      run_check("tie_hi", 24, 127, 1, 0);

      // Tie cleared by a later larger score.
      scores_in = '0;
      set_s(0, 5);
      set_s(1, 5);
      set_s(2, 6);
      run_check("tie_clr", 2, 6, 0, 2);

      // All equal non-zero.
      for (int k = 0; k < N; k++) set_s(k, 33);
      run_check("all_eq", 0, 33, 1, 0);

      // Snapshot isolation and start masking.
      for (int k = 0; k < N; k++) set_s(k, $urandom_range(0, 127));
      exp_snap = argmax_vec(scores_in);
      seen0 = results_seen;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 40; c++) begin
         start = (c == 5 || c == 26);
         for (int k = 0; k < N; k++) set_s(k, $urandom_range(0, 127));
         @(negedge clk);
      end
      start = 1'b0;
      chk("snap_valid", int'(res_valid), 1);
      chk("snap_idx",   int'(class_idx), int'(exp_snap[IW-1:0]));
      chk("snap_score", int'(max_score), int'(exp_snap[IW+W-1:IW]));
      chk("snap_tie",   int'(tie),       int'(exp_snap[IW+W]));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("snap_one_result", results_seen - seen0, 1);

      // Reset mid-scan, then a fresh search.
      for (int k = 0; k < N; k++) set_s(k, 100);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      #2 nrst = 1'b1;
      #1 check_all_zero("rst_mid");
      @(negedge clk);
      nrst = 1'b0;
      seen0 = results_seen;
      repeat (30) @(negedge clk);
      chk("rst_no_stale", results_seen - seen0, 0);
      scores_in = '0;
      set_s(8, 64);
      run_check("post_rst", 8, 64, 0, 0);

      // Randomized traffic: start/ready toggled freely, checked by the model.
      for (int run = 0; run < 8; run++) begin
         lim = (run % 2 == 0) ? 3 : 127;
         for (int cyc = 0; cyc < 120; cyc++) begin
            start     = ($urandom_range(0, 5) == 0);
            res_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
               for (int k = 0; k < N; k++) set_s(k, $urandom_range(0, lim));
            end
            @(negedge clk);
         end
      end
      start     = 1'b0;
      res_ready = 1'b1;
      repeat (40) @(negedge clk);
      chk("final_idle", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
